// File: rtl/alu_mcycle_if.sv
// Request/response bundle for alu_mcycle: valid/ready request carrying the
// operands and op select, valid/ready response carrying the result and EQ flag.
interface alu_mcycle_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ALUop1;
  logic [WIDTH-1:0] ALUop2;
  logic [3:0]       ALUctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUout;
  logic             EQ;

  // Requester side: issues operations and consumes results.
  modport master (
    output in_valid, ALUop1, ALUop2, ALUctrl, out_ready,
    input  in_ready, out_valid, ALUout, EQ
  );

  // ALU side.
  modport slave (
    input  in_valid, ALUop1, ALUop2, ALUctrl, out_ready,
    output in_ready, out_valid, ALUout, EQ
  );
endinterface

// File: rtl/alu_mcycle.sv
// Multi-cycle integer ALU: single-cycle logic/arith/compare/shift ops plus
// iterative shift-add multiply and restoring unsigned divide/remainder.
// One transaction in flight; the result and EQ flag are held until taken.
module alu_mcycle #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  alu_mcycle_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpAnd  = 4'h2;
  localparam logic [3:0] OpOr   = 4'h3;
  localparam logic [3:0] OpXor  = 4'h4;
  localparam logic [3:0] OpSlt  = 4'h5;
  localparam logic [3:0] OpSltu = 4'h6;
  localparam logic [3:0] OpSll  = 4'h7;
  localparam logic [3:0] OpSrl  = 4'h8;
  localparam logic [3:0] OpSra  = 4'h9;
  localparam logic [3:0] OpMul  = 4'hA;
  localparam logic [3:0] OpDivu = 4'hB;
  localparam logic [3:0] OpRemu = 4'hC;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q;
  logic [3:0]       op_q;
  // MUL: acc = partial product, opa = multiplicand, opb = multiplier.
  // DIV: acc = remainder, opa = dividend/quotient shift reg, opb = divisor.
  logic [WIDTH-1:0] acc_q, opa_q, opb_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q, out_valid_q, eq_q;
  logic [WIDTH-1:0] alu_out_q;

  logic [WIDTH-1:0] sc_result;
  logic [SHW-1:0]   shamt;
  logic             is_iter;

  assign shamt   = bus.ALUop2[SHW-1:0];
  assign is_iter = (bus.ALUctrl == OpMul) || (bus.ALUctrl == OpDivu) ||
                   (bus.ALUctrl == OpRemu);

  // Single-cycle result from the live request operands.
  always_comb begin
    sc_result = '0;
    case (bus.ALUctrl)
      OpAdd:  sc_result = bus.ALUop1 + bus.ALUop2;
      OpSub:  sc_result = bus.ALUop1 - bus.ALUop2;
      OpAnd:  sc_result = bus.ALUop1 & bus.ALUop2;
      OpOr:   sc_result = bus.ALUop1 | bus.ALUop2;
      OpXor:  sc_result = bus.ALUop1 ^ bus.ALUop2;
      OpSlt:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.ALUop1) < $signed(bus.ALUop2))};
      OpSltu: sc_result = {{(WIDTH-1){1'b0}}, (bus.ALUop1 < bus.ALUop2)};
      OpSll:  sc_result = bus.ALUop1 << shamt;
      OpSrl:  sc_result = bus.ALUop1 >> shamt;
      OpSra:  sc_result = $unsigned($signed(bus.ALUop1) >>> shamt);
      default: sc_result = '0;
    endcase
  end

  logic [WIDTH-1:0] mul_acc_d, mul_a_d, mul_b_d;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [WIDTH-1:0] div_rem_d, div_quo_d;
  logic [WIDTH-1:0] iter_result;

  // One iteration of shift-add multiply and restoring divide.
  // A zero divisor never borrows, giving an all-ones quotient and rem = dividend.
  always_comb begin
    mul_acc_d = opb_q[0] ? (acc_q + opa_q) : acc_q;
    mul_a_d   = opa_q << 1;
    mul_b_d   = opb_q >> 1;
    div_shift = {acc_q, opa_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (!div_diff[WIDTH]) begin
      div_rem_d = div_diff[WIDTH-1:0];
      div_quo_d = {opa_q[WIDTH-2:0], 1'b1};
    end else begin
      div_rem_d = div_shift[WIDTH-1:0];
      div_quo_d = {opa_q[WIDTH-2:0], 1'b0};
    end
    case (op_q)
      OpMul:   iter_result = mul_acc_d;
      OpDivu:  iter_result = div_quo_d;
      default: iter_result = div_rem_d;
    endcase
  end

  // Control FSM with registered handshake outputs, result and EQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      acc_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      eq_q        <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            op_q       <= bus.ALUctrl;
            in_ready_q <= 1'b0;
            if (is_iter) begin
              state_q <= StBusy;
              cnt_q   <= CW'(WIDTH);
              acc_q   <= '0;
              opa_q   <= bus.ALUop1;
              opb_q   <= bus.ALUop2;
            end else begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
              alu_out_q   <= sc_result;
              eq_q        <= (sc_result == '0);
            end
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - CW'(1);
          if (op_q == OpMul) begin
            acc_q <= mul_acc_d;
            opa_q <= mul_a_d;
            opb_q <= mul_b_d;
          end else begin
            acc_q <= div_rem_d;
            opa_q <= div_quo_d;
          end
          if (cnt_q == CW'(1)) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            alu_out_q   <= iter_result;
            eq_q        <= (iter_result == '0);
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ALUout    = alu_out_q;
  assign bus.EQ        = eq_q;
endmodule

// File: tb/tb_alu_mcycle.sv
// Directed self-checking bench for alu_mcycle (WIDTH=32).
module tb_alu_mcycle;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_mcycle_if #(.WIDTH(32)) bus ();

  alu_mcycle #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Issue one request, scramble the operands after acceptance, and count edges
  // from the acceptance edge (inclusive) until out_valid is seen.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic eq, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.ALUctrl  = op;
    bus.ALUop1   = a;
    bus.ALUop2   = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.ALUop1   = ~a;
    bus.ALUop2   = a ^ b ^ 32'h5A5A_0001;
    bus.ALUctrl  = 4'h0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.ALUout;
    eq  = bus.EQ;
    if (bus.out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.ALUop1    = '0;
    bus.ALUop2    = '0;
    bus.ALUctrl   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.ALUout !== 32'h0) begin
      errors++; $display("FAIL reset_aluout: got %h want 00000000", bus.ALUout);
    end
    checks++;
    if (bus.EQ !== 1'b1) begin
      errors++; $display("FAIL reset_eq: got %b want 1", bus.EQ);
    end
  endtask

  // Runs a table of ops, checking result, EQ and latency for each.
  task automatic run_table(input string tag, input int n, input logic [3:0] ops [8],
                           input logic [31:0] as [8], input logic [31:0] bs [8],
                           input logic [31:0] exps [8], input int exp_lat);
    logic [31:0] res;
    logic        eq;
    int          lat;
    for (int i = 0; i < n; i++) begin
      run_op(ops[i], as[i], bs[i], res, eq, lat);
      checks++;
      if (res !== exps[i]) begin
        errors++;
        $display("FAIL %s[%0d]_result: got %h want %h", tag, i, res, exps[i]);
      end
      checks++;
      if (eq !== (exps[i] == 32'h0)) begin
        errors++;
        $display("FAIL %s[%0d]_eq: got %b want %b", tag, i, eq, exps[i] == 32'h0);
      end
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL %s[%0d]_latency: got %0d want %0d", tag, i, lat, exp_lat);
      end
    end
  endtask

  task automatic test_single;
    logic [3:0]  ops  [8] = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h2, 4'h3, 4'h4, 4'hF};
    logic [31:0] as   [8] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h12345678};
    logic [31:0] bs   [8] = '{32'h1, 32'd7, 32'h1, 32'h1,
                              32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'h9};
    logic [31:0] exps [8] = '{32'h0, 32'hFFFFFFFE, 32'h1, 32'h0,
                              32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00, 32'h0};
    run_table("single", 8, ops, as, bs, exps, 1);
  endtask

  task automatic test_shift;
    logic [3:0]  ops  [8] = '{4'h9, 4'h8, 4'h7, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [31:0] as   [8] = '{32'h80000000, 32'h80000000, 32'h1, 32'h3, 0, 0, 0, 0};
    logic [31:0] bs   [8] = '{32'h24, 32'h24, 32'd31, 32'h21, 0, 0, 0, 0};
    logic [31:0] exps [8] = '{32'hF8000000, 32'h08000000, 32'h80000000, 32'h6, 0, 0, 0, 0};
    run_table("shift", 4, ops, as, bs, exps, 1);
  endtask

  task automatic test_mul;
    logic [3:0]  ops  [8] = '{4'hA, 4'hA, 4'hA, 0, 0, 0, 0, 0};
    logic [31:0] as   [8] = '{32'h00012345, 32'hFFFFFFFF, 32'd7, 0, 0, 0, 0, 0};
    logic [31:0] bs   [8] = '{32'h00010000, 32'hFFFFFFFF, 32'd6, 0, 0, 0, 0, 0};
    logic [31:0] exps [8] = '{32'h23450000, 32'h00000001, 32'd42, 0, 0, 0, 0, 0};
    run_table("mul", 3, ops, as, bs, exps, 33);
  endtask

  task automatic test_div;
    logic [3:0]  ops  [8] = '{4'hB, 4'hC, 4'hB, 4'hC, 4'hB, 4'hC, 0, 0};
    logic [31:0] as   [8] = '{32'd100, 32'd100, 32'hDEADBEEF, 32'hDEADBEEF,
                              32'h80000000, 32'h80000000, 0, 0};
    logic [31:0] bs   [8] = '{32'd7, 32'd7, 32'h0, 32'h0, 32'd3, 32'd3, 0, 0};
    logic [31:0] exps [8] = '{32'd14, 32'd2, 32'hFFFFFFFF, 32'hDEADBEEF,
                              32'h2AAAAAAA, 32'd2, 0, 0};
    run_table("div", 6, ops, as, bs, exps, 33);
  endtask

  task automatic test_backpressure;
    logic [31:0] res;
    logic        eq;
    int          lat;
    bus.out_ready = 1'b0;
    run_op(4'h0, 32'd3, 32'd4, res, eq, lat);
    checks++;
    if (res !== 32'd7 || lat != 1) begin
      errors++; $display("FAIL bp_first: got %h lat %0d want 00000007 lat 1", res, lat);
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.ALUop1   = 32'h1000 + 32'(i);
      bus.ALUop2   = 32'(i);
      bus.ALUctrl  = 4'h1;
      @(posedge clk); #1;
      checks++;
      if (bus.ALUout !== 32'd7 || bus.EQ !== 1'b0 || bus.in_ready !== 1'b0 ||
          bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got out=%h eq=%b rdy=%b vld=%b want 00000007 0 0 1",
                 i, bus.ALUout, bus.EQ, bus.in_ready, bus.out_valid);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    run_op(4'hE, 32'd5, 32'd6, res, eq, lat);
    checks++;
    if (res !== 32'h0 || eq !== 1'b1 || lat != 1) begin
      errors++;
      $display("FAIL bp_unused_op: got %h eq %b lat %0d want 00000000 1 1", res, eq, lat);
    end
  endtask

  task automatic test_back_to_back;
    bus.out_ready = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_idle: got rdy=%b want 1", bus.in_ready);
    end
    bus.ALUctrl  = 4'h0;
    bus.ALUop1   = 32'd1;
    bus.ALUop2   = 32'd1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.ALUout !== 32'd2) begin
      errors++; $display("FAIL b2b_first: got vld=%b out=%h want 1 00000002",
                         bus.out_valid, bus.ALUout);
    end
    bus.ALUop1 = 32'd3;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.ALUout !== 32'd2) begin
      errors++; $display("FAIL b2b_gap: got vld=%b rdy=%b out=%h want 0 1 00000002",
                         bus.out_valid, bus.in_ready, bus.ALUout);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.ALUout !== 32'd4) begin
      errors++; $display("FAIL b2b_second: got vld=%b out=%h want 1 00000004",
                         bus.out_valid, bus.ALUout);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_busy;
    int seen;
    bus.out_ready = 1'b1;
    bus.ALUctrl   = 4'hB;
    bus.ALUop1    = 32'd100;
    bus.ALUop2    = 32'd7;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rb_busy: got rdy=%b vld=%b want 0 0", bus.in_ready, bus.out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.ALUout !== 32'h0 ||
        bus.EQ !== 1'b1) begin
      errors++;
      $display("FAIL rb_after_reset: got rdy=%b vld=%b out=%h eq=%b want 1 0 00000000 1",
               bus.in_ready, bus.out_valid, bus.ALUout, bus.EQ);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rb_no_result: got %0d valid cycles want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_shift();
    test_mul();
    test_div();
    test_backpressure();
    test_back_to_back();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
